// File: rtl/des_pkg.sv
// des_pkg: DES key-schedule tables, shift table, state type and rotation helpers
package des_pkg;
  typedef enum logic {IDLE, GEN} state_t;
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };
  localparam int S [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction
  function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction
endpackage

// File: rtl/des_pc1.sv
// des_pc1: permuted choice 1, 64-bit key to C||D with CD bit 1 at the MSB
module des_pc1
  import des_pkg::*;
(
  input  logic [64:1] key,
  output logic [55:0] cd
);
  logic unused_parity;
  assign unused_parity = ^{key[8], key[16], key[24], key[32], key[40], key[48], key[56], key[64]};
  for (genvar i = 0; i < 56; i++) begin : g_bit
    assign cd[55-i] = key[PC1[i]];
  end
endmodule

// File: rtl/des_pc2.sv
// des_pc2: permuted choice 2, C||D (CD bit 1 at the MSB) to a 48-bit subkey
module des_pc2
  import des_pkg::*;
(
  input  logic [55:0] cd,
  output logic [48:1] subkey
);
  for (genvar i = 0; i < 48; i++) begin : g_bit
    assign subkey[i+1] = cd[56-PC2[i]];
  end
endmodule

// File: rtl/des_key_schedule.sv
// des_key_schedule: streams the 16 DES round subkeys, forward or reversed, per accepted key
module des_key_schedule
  import des_pkg::*;
#(
  parameter int PARITY_CHECK = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [64:1] key,
  input  logic        decrypt,
  input  logic        flush,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [48:1] subkey,
  output logic [3:0]  round,
  output logic        last,
  output logic        parity_err
);
  state_t state;
  logic [27:0] c, d;
  logic dec, two, even_byte;
  logic [55:0] pc1_cd;
  des_pc1 u_pc1 (.key(key), .cd(pc1_cd));
  des_pc2 u_pc2 (.cd({c, d}), .subkey(subkey));
  assign key_ready = state == IDLE;
  assign subkey_valid = state == GEN;
  assign last = subkey_valid && round == 4'd15;
  assign two = S[dec ? 4'd15 - round : round + 4'd1] == 2;
  // any key byte with an even number of ones violates DES odd parity
  always_comb begin
    even_byte = 1'b0;
    for (int k = 0; k < 8; k++) even_byte = even_byte | ~^key[8*k+1 +: 8];
  end
  // encrypt preloads C1/D1; decrypt starts from C16 = C0 and walks backwards
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      round <= '0;
      c <= '0;
      d <= '0;
      dec <= 1'b0;
      parity_err <= 1'b0;
    end else if (state == IDLE) begin
      if (key_valid) begin
        state <= GEN;
        round <= '0;
        dec <= decrypt;
        c <= decrypt ? pc1_cd[55:28] : rotl(pc1_cd[55:28], 1'b0);
        d <= decrypt ? pc1_cd[27:0] : rotl(pc1_cd[27:0], 1'b0);
        parity_err <= PARITY_CHECK != 0 && even_byte;
      end
    end else if (flush) begin
      state <= IDLE;
      round <= '0;
    end else if (subkey_ready) begin
      if (last) begin
        state <= IDLE;
        round <= '0;
      end else begin
        round <= round + 4'd1;
        c <= dec ? rotr(c, two) : rotl(c, two);
        d <= dec ? rotr(d, two) : rotl(d, two);
      end
    end
  end
endmodule

// File: tb/tb_des_key_schedule.sv
// tb_des_key_schedule: scoreboard bench driving parity-checking and plain instances in lockstep
module tb_des_key_schedule;
  typedef struct {
    logic [47:0] sk;
    logic [3:0]  rnd;
    logic        lst;
  } exp_t;
  localparam logic [63:0] K = 64'h133457799BBCDFF1;
  localparam logic [63:0] KP = 64'h123556789ABDDEF0;
  localparam logic [47:0] KS [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };
  logic clk, rst, key_valid, decrypt, flush, subkey_ready;
  logic [64:1] key;
  logic key_ready, subkey_valid, last, parity_err;
  logic [48:1] subkey;
  logic [3:0] round;
  logic key_ready_0, subkey_valid_0, last_0, parity_err_0;
  logic [48:1] subkey_0;
  logic [3:0] round_0;
  exp_t q[$];
  int tests = 0;
  int fails = 0;
  des_key_schedule #(.PARITY_CHECK(1)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready), .key(key),
    .decrypt(decrypt), .flush(flush), .subkey_valid(subkey_valid), .subkey_ready(subkey_ready),
    .subkey(subkey), .round(round), .last(last), .parity_err(parity_err)
  );
  des_key_schedule #(.PARITY_CHECK(0)) dut0 (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready_0), .key(key),
    .decrypt(decrypt), .flush(flush), .subkey_valid(subkey_valid_0), .subkey_ready(subkey_ready),
    .subkey(subkey_0), .round(round_0), .last(last_0), .parity_err(parity_err_0)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [64:1] to_key(input logic [63:0] h);
    logic [64:1] k;
    for (int i = 1; i <= 64; i++) k[i] = h[64-i];
    return k;
  endfunction
  function automatic logic [47:0] from_sk(input logic [48:1] s);
    logic [47:0] r;
    for (int i = 1; i <= 48; i++) r[48-i] = s[i];
    return r;
  endfunction
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask
  task automatic push_seq(input logic dec, input logic zero, input int n);
    for (int r = 0; r < n; r++) begin
      exp_t e;
      e.sk = zero ? 48'h0 : (dec ? KS[15-r] : KS[r]);
      e.rnd = r[3:0];
      e.lst = r == 15;
      q.push_back(e);
    end
  endtask
  task automatic load(input logic [63:0] h, input logic dec, input logic fl, output int waited);
    key = to_key(h);
    decrypt = dec;
    flush = fl;
    key_valid = 1'b1;
    waited = 0;
    while (!key_ready && waited < 100) begin
      @(posedge clk);
      #1;
      waited++;
    end
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    flush = 1'b0;
  endtask
  task automatic drain(input logic rnd, output int n);
    n = 0;
    while (subkey_valid && n < 400) begin
      subkey_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    subkey_ready = 1'b1;
    check("drain_timeout", 64'(n >= 400), 64'd0);
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_key_ready"}, 64'(key_ready), 64'd1);
    check({tag, "_subkey_valid"}, 64'(subkey_valid), 64'd0);
    check({tag, "_round"}, 64'(round), 64'd0);
    check({tag, "_last"}, 64'(last), 64'd0);
    check({tag, "_parity_err"}, 64'(parity_err), 64'd0);
    check({tag, "_subkey"}, 64'(from_sk(subkey)), 64'd0);
  endtask
  // scoreboard monitor: every presented subkey must match the queue head; pop on handshake
  always @(negedge clk) begin
    if (subkey_valid) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_subkey: got round %0d subkey %h, required no output", round, from_sk(subkey));
      end else begin
        exp_t e;
        e = q[0];
        tests++;
        if (from_sk(subkey) !== e.sk || round !== e.rnd || last !== e.lst) begin
          fails++;
          $display("FAIL subkey: got %h round %0d last %0d, required %h round %0d last %0d",
                   from_sk(subkey), round, last, e.sk, e.rnd, e.lst);
        end
        tests++;
        if (from_sk(subkey_0) !== e.sk || subkey_valid_0 !== 1'b1 || round_0 !== e.rnd) begin
          fails++;
          $display("FAIL subkey_noparity: got %h valid %0d round %0d, required %h valid 1 round %0d",
                   from_sk(subkey_0), subkey_valid_0, round_0, e.sk, e.rnd);
        end
        if (subkey_ready) void'(q.pop_front());
      end
    end
  end
  initial begin
    int w, n;
    rst = 1'b1;
    key_valid = 1'b0;
    key = '0;
    decrypt = 1'b0;
    flush = 1'b0;
    subkey_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    push_seq(1'b0, 1'b0, 16);
    load(K, 1'b0, 1'b0, w);
    check("enc_parity_err", 64'(parity_err), 64'd0);
    check("enc_parity_err_p0", 64'(parity_err_0), 64'd0);
    push_seq(1'b1, 1'b0, 16);
    load(K, 1'b1, 1'b0, w);
    check("b2b_wait_cycles", 64'(w), 64'd16);
    drain(1'b0, n);
    check("dec_consecutive", 64'(n), 64'd16);
    push_seq(1'b0, 1'b0, 16);
    load(K, 1'b0, 1'b0, w);
    drain(1'b1, n);
    push_seq(1'b0, 1'b0, 6);
    load(K, 1'b0, 1'b0, w);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_key_ready", 64'(key_ready), 64'd1);
    check("flush_subkey_valid", 64'(subkey_valid), 64'd0);
    @(posedge clk);
    #1;
    check("flush_no_round6", 64'(subkey_valid), 64'd0);
    push_seq(1'b1, 1'b0, 16);
    load(K, 1'b1, 1'b1, w);
    check("flush_idle_wait", 64'(w), 64'd0);
    drain(1'b0, n);
    check("after_flush_consecutive", 64'(n), 64'd16);
    push_seq(1'b0, 1'b0, 8);
    load(KP, 1'b0, 1'b0, w);
    check("pbits_parity_err", 64'(parity_err), 64'd1);
    check("pbits_parity_err_p0", 64'(parity_err_0), 64'd0);
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs("midreset");
    push_seq(1'b0, 1'b1, 16);
    load(64'h0, 1'b0, 1'b0, w);
    check("zero_parity_err", 64'(parity_err), 64'd1);
    check("zero_parity_err_p0", 64'(parity_err_0), 64'd0);
    drain(1'b0, n);
    check("zero_parity_sticky", 64'(parity_err), 64'd1);
    push_seq(1'b1, 1'b0, 16);
    load(K, 1'b1, 1'b0, w);
    check("clear_parity_err", 64'(parity_err), 64'd0);
    drain(1'b1, n);
    repeat (2) @(posedge clk);
    #1;
    check("queue_empty", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/des_key_schedule.md
DES_KEY_SCHEDULE -- requirements
Module: des_key_schedule

Interface
REQ-001 SHALL have parameter PARITY_CHECK, default 0: 1 enables the key parity check; 0 ties parity_err to 0.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port key_valid, input, 1: key and decrypt are valid.
REQ-005 SHALL have port key_ready, output, 1: block can accept a key.
REQ-006 SHALL have port key, input, [64:1]: key[i] = FIPS 46-3 bit i (bit 1 = leftmost hex bit).
REQ-007 SHALL have port decrypt, input, 1: 0 emits K1..K16, 1 emits K16..K1; sampled on key handshake.
REQ-008 SHALL have port flush, input, 1: abort the current schedule.
REQ-009 SHALL have port subkey_valid, output, 1: subkey, round and last are valid.
REQ-010 SHALL have port subkey_ready, input, 1: downstream accepts the subkey.
REQ-011 SHALL have port subkey, output, [48:1]: subkey[i] = FIPS subkey bit i.
REQ-012 SHALL have port round, output, 4: output index 0..15.
REQ-013 SHALL have port last, output, 1: high with the 16th subkey of a schedule.
REQ-014 SHALL have port parity_err, output, 1: sticky, for the most recently accepted key.

Function
REQ-015 SHALL implement two states, IDLE and GEN; key_ready = 1 only in IDLE and subkey_valid = 1 only in GEN.
REQ-016 On key handshake (key_valid & key_ready) SHALL: load C/D registers with PC1(key), latch decrypt, set round = 0 and enter GEN.
REQ-017 On the key handshake, C/D SHALL be rotated left by 1 when encrypting and left unrotated (C16 = C0) when decrypting.
REQ-018 SHALL drive subkey = PC2(C,D) combinationally from the registers; latency key handshake -> first subkey_valid is 1 cycle.
REQ-019 SHALL hold subkey, round and last stable while subkey_valid & !subkey_ready.
REQ-020 On subkey handshake with round < 15 SHALL increment round and advance C/D: encrypt rotl by S[round+2]; decrypt rotr by S[16-round]; 1-based shift table S = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-021 Rotations SHALL be 28-bit circular, applied independently to C and D.
REQ-022 last SHALL be 1 iff GEN and round == 15; on handshake with last = 1 the block SHALL return to IDLE.
REQ-023 Throughput SHALL be at most one key per 17 cycles; a key is never accepted in the cycle of the last subkey handshake.
REQ-024 flush in GEN SHALL force IDLE on the next cycle; flush SHALL win over a simultaneous subkey handshake; flush in IDLE is ignored and SHALL NOT block a key handshake.
REQ-025 With PARITY_CHECK = 1, on key handshake parity_err SHALL be set to 1 if any byte key[8k-7:8k], k = 1..8, has even parity, else 0, and held until the next key handshake.
REQ-026 Key bits 8,16,...,64 SHALL NOT affect subkey.

Reset
REQ-027 rst SHALL force: state IDLE, key_ready = 1 after reset, subkey_valid = 0, round = 0, last = 0, parity_err = 0, C/D = 0.
REQ-028 rst SHALL take priority over flush and over both handshakes, including mid-schedule.

Structure
REQ-029 A shared package des_pkg SHALL hold the PC1 and PC2 tables, the shift table S, and the state enum.
REQ-030 PC2 SHALL be one combinational sub-module des_pc2 (56 -> 48); PC1 SHALL reuse the existing PC1 block.
REQ-031 The block SHALL be fully synchronous with no latches.

Verification
REQ-032 Key FIPS 133457799BBCDFF1, decrypt = 0, subkey_ready = 1 -> round 0 subkey = 1B02EFFC7072, round 15 subkey = CB3D8B0E17F5 with last = 1, 16 consecutive valid cycles.
REQ-033 Same key, decrypt = 1 -> round 0 subkey = CB3D8B0E17F5, round 15 subkey = 1B02EFFC7072; full sequence equals the reversed encrypt sequence.
REQ-034 subkey_ready toggled pseudo-randomly -> every subkey stable while stalled, none lost or duplicated, round monotonic 0..15.
REQ-035 flush at round 5 coincident with a subkey handshake -> IDLE next cycle, key_ready = 1, no round 6; new key then accepted normally; rst asserted at round 7 -> all outputs at reset values next cycle.
REQ-036 PARITY_CHECK = 1: key 133457799BBCDFF1 -> parity_err = 0; key 0000000000000000 -> parity_err = 1, subkeys all 0; same two keys with PARITY_CHECK = 0 -> parity_err = 0 throughout.
